// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the iteration-counter sizing helper.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] kept;
    logic           borrow;
    logic           unused_kept_msb;

    assign shifted         = {rem_i, bit_i};
    assign {borrow, diff}  = {1'b0, shifted} - {2'b00, divisor_i};
    assign q_o             = ~borrow;
    assign kept            = q_o ? diff : shifted;
    // The kept value is always below the divisor, so its top bit is zero.
    assign rem_o           = kept[WIDTH-1:0];
    assign unused_kept_msb = kept[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, one quotient bit per cycle (MSB first).
// Divide-by-zero short-circuits straight to DONE with saturated quotient.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // shreg_q shifts dividend bits out of the top while quotient bits enter
    // at the bottom; after WIDTH steps it holds the full quotient.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (shreg_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    shreg_d = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    dbz_d   = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        quo_d   = '1;
                        remo_d  = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CW'(WIDTH);
                    end
                end
            end
            RUN: begin
                rem_d   = step_rem;
                shreg_d = {shreg_q[WIDTH-2:0], step_q};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quo_d   = {shreg_q[WIDTH-2:0], step_q};
                    remo_d  = step_rem;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider (WIDTH=8) against plain
// integer division, including latency, busy duration and reset behaviour.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one division and follow it to its done pulse; returns in the done
    // cycle so the caller may start the next request back-to-back.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        int          lat;
        int          busy_cnt;
        int unsigned exp_q, exp_r, exp_lat, exp_busy;
        if (b == 0) begin
            exp_q = (1 << W) - 1; exp_r = a; exp_lat = 1; exp_busy = 0;
        end else begin
            exp_q = a / b; exp_r = a % b; exp_lat = W + 1; exp_busy = W;
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat      = 1;
        busy_cnt = 0;
        chk("dbz_after_accept", 32'(div_by_zero), 32'(b == 0));
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            if (inject && lat == 3) begin
                start = 1'b1; dividend = 9; divisor = 2;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        chk("latency",     lat,              exp_lat);
        chk("busy_cycles", busy_cnt,         exp_busy);
        chk("busy_at_done", 32'(busy),       0);
        chk("quotient",    32'(quotient),    exp_q);
        chk("remainder",   32'(remainder),   exp_r);
        chk("div_by_zero", 32'(div_by_zero), 32'(b == 0));
        $display("[TB] %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d", a, b, quotient, remainder,
                 div_by_zero, lat);
    endtask

    initial begin
        int dones;
        logic [W-1:0] ra, rb;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_q",    32'(quotient), 0);
        chk("rst_r",    32'(remainder), 0);
        chk("rst_dbz",  32'(div_by_zero), 0);

        run_div(100, 7, 0);
        tick();
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_idle",      32'(busy), 0);
        chk("q_held",         32'(quotient), 14);
        chk("r_held",         32'(remainder), 2);

        run_div(255, 1, 0); tick();
        run_div(5, 9, 0);   tick();
        run_div(0, 3, 0);   tick();

        run_div(200, 0, 0);
        run_div(10, 3, 0);
        tick();

        run_div(50, 5, 1);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        chk("ignored_start_no_done", dones, 0);

        start = 1'b1; dividend = 77; divisor = 4;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_q",    32'(quotient), 0);
        chk("abort_r",    32'(remainder), 0);
        chk("abort_dbz",  32'(div_by_zero), 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);

        rst = 1'b1; start = 1'b1; dividend = 77; divisor = 4;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", 32'(busy), 0);
        tick();
        chk("rst_prio_idle", 32'(busy | done), 0);

        run_div(77, 4, 0);
        for (int i = 0; i < 2000; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(0, 255));
            run_div(ra, rb, 0);
        end
        tick();
        chk("final_idle", 32'(busy | done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
